// File: rtl/vr_tooth_decoder.sv
`timescale 1ns/1ps
// Crank trigger-wheel decoder: synchronises and filters the VR input, measures tooth
// periods and tracks missing-tooth sync. Optional noise window: define VR_NOISE_WINDOW_EN.
module vr_tooth_decoder #(
  parameter int TEETH_TOTAL = 36,
  parameter int MISSING     = 1,
  parameter int FILTER_LEN  = 4,
  parameter int PERIOD_W    = 16,
  parameter int IDX_W       = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vrin,
  output logic                synced,
  output logic                tooth_strobe,
  output logic                rev_strobe,
  output logic [IDX_W-1:0]    tooth_index,
  output logic [PERIOD_W-1:0] tooth_period,
  output logic                sync_err
);

  localparam int FCNT_W = $clog2(FILTER_LEN) + 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(TEETH_TOTAL - MISSING - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
  localparam logic [FCNT_W-1:0]   FCNT_TOP = FCNT_W'(FILTER_LEN - 1);
  localparam logic [FCNT_W-1:0]   FCNT_ONE = FCNT_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SYNCED = 2'd2
  } state_t;

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                vr_filt_q, vr_filt_d;
  logic                vr_prev_q, vr_prev_d;
  logic [FCNT_W-1:0]   filt_cnt_q, filt_cnt_d;
  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] prev_q, prev_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                synced_q, synced_d;
  logic                tooth_q, tooth_d;
  logic                rev_q, rev_d;
  logic                err_q, err_d;

  logic                edge_s;
  logic                sat_s;
  logic                gap_s;
  logic                noise_s;
  logic                accept_s;
  logic [PERIOD_W+1:0] cur_x2_s;
  logic [PERIOD_W+1:0] prev_x3_s;

  // Synchroniser and glitch filter: the filtered level moves only after FILTER_LEN equal samples.
  always_comb begin
    sync1_d    = vrin;
    sync2_d    = sync1_q;
    vr_filt_d  = vr_filt_q;
    filt_cnt_d = filt_cnt_q;
    vr_prev_d  = vr_filt_q;
    if (sync2_q == vr_filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FCNT_TOP) begin
      vr_filt_d  = sync2_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + FCNT_ONE;
    end
  end

  assign edge_s    = vr_filt_q & ~vr_prev_q;
  assign sat_s     = (cnt_q == CNT_MAX);
  assign cur_x2_s  = {1'b0, cnt_q, 1'b0};
  assign prev_x3_s = {2'b00, prev_q} + {1'b0, prev_q, 1'b0};
  // A saturated count carries no timing information, so it can never mark the gap.
  assign gap_s     = ~sat_s & (cur_x2_s > prev_x3_s);

`ifdef VR_NOISE_WINDOW_EN
  assign noise_s   = (state_q == ST_SYNCED) && (cnt_q < (period_q >> 2'd2));
`else
  assign noise_s   = 1'b0;
`endif

  assign accept_s  = edge_s & ~noise_s;

  // Period counter, gap detection and sync state machine.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    period_d = period_q;
    tooth_d  = 1'b0;
    rev_d    = 1'b0;
    err_d    = 1'b0;
    if (accept_s) begin
      cnt_d    = CNT_ONE;
      prev_d   = cnt_q;
      period_d = cnt_q;
      if (sat_s) begin
        state_d = ST_ARMED;
        idx_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_ARMED;
            idx_d   = '0;
          end
          ST_ARMED: begin
            if (gap_s) begin
              state_d = ST_SYNCED;
              idx_d   = '0;
              tooth_d = 1'b1;
              rev_d   = 1'b1;
            end else begin
              state_d = ST_ARMED;
              idx_d   = '0;
            end
          end
          ST_SYNCED: begin
            if (gap_s) begin
              if (idx_q == LAST_IDX) begin
                idx_d   = '0;
                tooth_d = 1'b1;
                rev_d   = 1'b1;
              end else begin
                state_d = ST_ARMED;
                idx_d   = '0;
                err_d   = 1'b1;
              end
            end else begin
              if (idx_q < LAST_IDX) begin
                idx_d   = idx_q + IDX_ONE;
                tooth_d = 1'b1;
              end else begin
                state_d = ST_ARMED;
                idx_d   = '0;
                err_d   = 1'b1;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        endcase
      end
    end else if (sat_s) begin
      // Wheel stalled: drop sync quietly and keep the last measured period.
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    synced_d = (state_d == ST_SYNCED);
  end

  // All state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      vr_filt_q  <= 1'b0;
      vr_prev_q  <= 1'b0;
      filt_cnt_q <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      prev_q     <= '0;
      period_q   <= '0;
      idx_q      <= '0;
      synced_q   <= 1'b0;
      tooth_q    <= 1'b0;
      rev_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      vr_filt_q  <= vr_filt_d;
      vr_prev_q  <= vr_prev_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      period_q   <= period_d;
      idx_q      <= idx_d;
      synced_q   <= synced_d;
      tooth_q    <= tooth_d;
      rev_q      <= rev_d;
      err_q      <= err_d;
    end
  end

  assign synced       = synced_q;
  assign tooth_strobe = tooth_q;
  assign rev_strobe   = rev_q;
  assign tooth_index  = idx_q;
  assign tooth_period = period_q;
  assign sync_err     = err_q;

endmodule
